// File: rtl/seg7_disp_arbiter.sv
// ============================================================================
// Module      : seg7_disp_arbiter
// Description : Two-requester arbiter for a shared seven-segment display with
//               a minimum dwell before preemption. Defining SEG_ARB_GAP_EN
//               inserts a blanking GAP state between owners.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_disp_arbiter #(
    parameter int HOLD_CYCLES = 50000,
    parameter int GAP_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [31:0] disp_x,
    output logic        disp_blank
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_own0 = 2'd1;
    localparam logic [1:0] c_st_own1 = 2'd2;
`ifdef SEG_ARB_GAP_EN
    localparam logic [1:0] c_st_gap  = 2'd3;
    localparam logic [7:0] c_gap_last = 8'(GAP_CYCLES - 1);
`endif
    localparam logic [15:0] c_hold_last = 16'(HOLD_CYCLES - 1);

    // Out-of-range parameters stop elaboration rather than silently wrapping.
    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
            $error("seg7_disp_arbiter: HOLD_CYCLES out of range 1..65535");
        end
        if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
            $error("seg7_disp_arbiter: GAP_CYCLES out of range 1..255");
        end
    endgenerate

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [15:0] r_dwell;
    logic [15:0] w_dwell_next;
    logic        r_last_owner;
    logic        w_last_owner_next;
    logic        r_gnt0;
    logic        r_gnt1;
    logic [31:0] r_disp_x;
    logic        r_disp_blank;
`ifdef SEG_ARB_GAP_EN
    logic [7:0]  r_gap_cnt;
    logic [7:0]  w_gap_cnt_next;
    logic        r_gap_tgt;
    logic        w_gap_tgt_next;
`endif

    logic w_in_own;
    logic w_enter_own;

    assign w_in_own    = (r_state == c_st_own0) || (r_state == c_st_own1);
    assign w_enter_own = ((w_next == c_st_own0) || (w_next == c_st_own1)) && (w_next != r_state);

    always_comb begin
        w_next            = r_state;
        w_last_owner_next = r_last_owner;
`ifdef SEG_ARB_GAP_EN
        w_gap_cnt_next    = r_gap_cnt;
        w_gap_tgt_next    = r_gap_tgt;
`endif
        case (r_state)
            c_st_idle: begin
                if (req0 && req1) begin
                    w_next = r_last_owner ? c_st_own0 : c_st_own1;
                end else if (req0) begin
                    w_next = c_st_own0;
                end else if (req1) begin
                    w_next = c_st_own1;
                end
            end
            c_st_own0: begin
                if (!req0 || (req1 && (r_dwell == c_hold_last))) begin
                    w_last_owner_next = 1'b0;
                    if (req1) begin
`ifdef SEG_ARB_GAP_EN
                        w_next         = c_st_gap;
                        w_gap_tgt_next = 1'b1;
                        w_gap_cnt_next = 8'd0;
`else
                        w_next = c_st_own1;
`endif
                    end else begin
                        w_next = c_st_idle;
                    end
                end
            end
            c_st_own1: begin
                if (!req1 || (req0 && (r_dwell == c_hold_last))) begin
                    w_last_owner_next = 1'b1;
                    if (req0) begin
`ifdef SEG_ARB_GAP_EN
                        w_next         = c_st_gap;
                        w_gap_tgt_next = 1'b0;
                        w_gap_cnt_next = 8'd0;
`else
                        w_next = c_st_own0;
`endif
                    end else begin
                        w_next = c_st_idle;
                    end
                end
            end
`ifdef SEG_ARB_GAP_EN
            c_st_gap: begin
                // Target first, then fall back to the owner that just left.
                if (r_gap_cnt == c_gap_last) begin
                    if (r_gap_tgt ? req1 : req0) begin
                        w_next = r_gap_tgt ? c_st_own1 : c_st_own0;
                    end else if (r_gap_tgt ? req0 : req1) begin
                        w_next = r_gap_tgt ? c_st_own0 : c_st_own1;
                    end else begin
                        w_next = c_st_idle;
                    end
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 8'd1;
                end
            end
`endif
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    // Dwell saturates so a late request from the other side preempts at once.
    always_comb begin
        w_dwell_next = r_dwell;
        if (w_enter_own) begin
            w_dwell_next = 16'd0;
        end else if (w_in_own && (r_dwell != c_hold_last)) begin
            w_dwell_next = r_dwell + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_dwell      <= 16'd0;
            r_last_owner <= 1'b1;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
`ifdef SEG_ARB_GAP_EN
            r_gap_cnt    <= 8'd0;
            r_gap_tgt    <= 1'b0;
`endif
        end else begin
            r_state      <= w_next;
            r_dwell      <= w_dwell_next;
            r_last_owner <= w_last_owner_next;
            r_gnt0       <= (w_next == c_st_own0);
            r_gnt1       <= (w_next == c_st_own1);
`ifdef SEG_ARB_GAP_EN
            r_gap_cnt    <= w_gap_cnt_next;
            r_gap_tgt    <= w_gap_tgt_next;
`endif
        end
    end

    // Display path follows the owner of the current cycle, one cycle behind the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp_x     <= 32'h0;
            r_disp_blank <= 1'b1;
        end else if (r_state == c_st_own0) begin
            r_disp_x     <= data0;
            r_disp_blank <= 1'b0;
        end else if (r_state == c_st_own1) begin
            r_disp_x     <= data1;
            r_disp_blank <= 1'b0;
        end else begin
            r_disp_blank <= 1'b1;
        end
    end

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign disp_x     = r_disp_x;
    assign disp_blank = r_disp_blank;

endmodule

`default_nettype wire
